sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Synchronous request/response controller that sits directly upstream of the combinational SRAM array (`SRAM_comb`-style, chip-select plus write-enable, no internal read register). It accepts single-word read/write requests from the processor datapath over a valid/ready handshake. It holds address and data stable for a programmable setup window, then pulses a one-cycle chip-select access. It registers read data and returns a response over a second valid/ready handshake. One transaction is in flight at a time.

## Interface
- N, 4, number of SRAM words
- W, 4, data width in bits
- A, $clog2(N), address width
- SETUP_CYC, 1, cycles that address/data/we are held before the access cycle (0 allowed)

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  A  word address
- req_wdata  input  W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_rdata  output  W  read data (0 for writes and errors)
- rsp_err  output  1  address was out of range (addr >= N)
- mem_cs  output  1  SRAM chip select
- mem_wr_en  output  1  SRAM write enable
- mem_addr  output  A  SRAM address
- mem_wr_data  output  W  SRAM write data
- mem_rd_data  input  W  SRAM combinational read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we/addr/wdata into holding registers.
  - If latched addr >= N, go to RESP with rsp_err=1 and no SRAM access.
  - Otherwise go to SETUP, or to ACCESS if SETUP_CYC==0.
- SETUP:
  - mem_addr/mem_wr_data/mem_wr_en driven from the holding registers; mem_cs=0.
  - Down-counter loaded with SETUP_CYC-1 on entry; move to ACCESS when it reaches 0.
- ACCESS (exactly one cycle):
  - mem_cs=1, mem_wr_en=held we.
  - Read: capture mem_rd_data into rsp_rdata at the end of the cycle.
  - Write: rsp_rdata <= 0.
  - Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready.
  - On rsp_ready: go to IDLE, clear rsp_valid.
- req_ready=0 in every state except IDLE. There is no request/response overlap: a new request can be accepted at the earliest in the cycle after the handshake cycle (rsp_valid && rsp_ready).
- mem_cs=0 in every state except ACCESS. mem_wr_en=0 whenever mem_cs=0 in IDLE and RESP.
- In SETUP, mem_wr_en reflects the held we, so the write-enable setup time is met.
- mem_addr and mem_wr_data hold their last values in IDLE and RESP; they are not glitched to 0.
- Counter width is $clog2(SETUP_CYC+1), with a minimum of 1 bit. It does not wrap: it saturates at 0.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_cs=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, counter=0.
- Request accepted at edge T (req_valid sampled with req_ready=1).
- SETUP occupies T+1..T+SETUP_CYC. ACCESS (mem_cs=1) is cycle T+SETUP_CYC+1. rsp_valid rises at T+SETUP_CYC+2.
- Latency from accept to rsp_valid is SETUP_CYC+2 cycles; an error response has latency 1.
- A back-pressured response (rsp_ready=0) stalls in RESP indefinitely with outputs stable.
- rst asserted mid-transaction: the next edge forces the reset values.
  - An in-progress ACCESS is aborted with mem_cs=0; no response is issued.
  - A write whose ACCESS edge coincides with rst is not guaranteed to have landed.
- req_valid with req_ready=0 is ignored; the requester must hold it.

## Structure
- Shared package `mem_pkg`: state encoding localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3) and the default N/W/SETUP_CYC values, shared with the SRAM and its testbench.
- Single flat module; no sub-module is needed.
- The SRAM is instantiated alongside this block at the memory-subsystem top, not inside it.

## Test plan
- Write then read, N=4, W=4, SETUP_CYC=1:
  - Write addr=2, data=4'hA, then read addr=2.
  - Write: mem_cs high for exactly 1 cycle with mem_wr_en=1, 2 cycles after accept.
  - Read: rsp_valid at accept+3 with rsp_rdata=4'hA, rsp_err=0.
- SETUP_CYC=0:
  - Read addr=1 after writing 4'h5.
  - mem_cs at accept+1, rsp_valid at accept+2, rsp_rdata=4'h5.
- Back-pressure:
  - Read with rsp_ready=0 for 5 cycles.
  - rsp_valid and rsp_rdata stable throughout; req_ready=0; released on rsp_ready=1, then req_ready=1 next cycle.
- Out of range, N=3:
  - Request addr=3.
  - rsp_err=1 at accept+1, rsp_rdata=0, mem_cs never asserted.
- Reset mid-SETUP (SETUP_CYC=3):
  - Assert rst at accept+2.
  - Next edge: all outputs at reset values, no mem_cs pulse, no rsp_valid.
- Write data integrity:
  - Write all 4 addresses with 4'h1..4'h4, then read back in reverse order.
  - Responses return 4'h4, 4'h3, 4'h2, 4'h1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM subsystem: state encoding and default geometry.
package mem_pkg;

    localparam int DEF_N         = 4;
    localparam int DEF_W         = 4;
    localparam int DEF_SETUP_CYC = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/sram_access_ctrl.sv
// Single-outstanding request/response front end for a combinational SRAM:
// holds address/data for SETUP_CYC cycles, pulses chip-select once, registers the result.
module sram_access_ctrl
    import mem_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int W         = DEF_W,
    parameter int A         = (N > 1) ? $clog2(N) : 1,
    parameter int SETUP_CYC = DEF_SETUP_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [A-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         mem_cs,
    output logic         mem_wr_en,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_wr_data,
    input  logic [W-1:0] mem_rd_data
);

    localparam int CW = (SETUP_CYC > 0) ? $clog2(SETUP_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((SETUP_CYC == 0) ? 0 : SETUP_CYC - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          addr_bad;

    assign addr_bad = (32'(req_addr) >= N);

    // NOTE: every output is a register updated on the transition into the state
    // that owns it, so mem_cs/mem_wr_en never glitch and all state uses <=.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mem_cs      <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (addr_bad) begin
                            // Out-of-range: answer immediately, SRAM pins untouched.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            rsp_err     <= 1'b0;
                            mem_addr    <= req_addr;
                            mem_wr_data <= req_wdata;
                            mem_wr_en   <= req_we;
                            if (SETUP_CYC == 0) begin
                                state  <= ACCESS;
                                mem_cs <= 1'b1;
                            end else begin
                                state <= SETUP;
                                cnt   <= CNT_LOAD;
                            end
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state  <= ACCESS;
                        mem_cs <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    mem_cs    <= 1'b0;
                    mem_wr_en <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= mem_wr_en ? '0 : mem_rd_data;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: three instances (N=4/S=1, N=4/S=0, N=3/S=3), each with a
// behavioural combinational SRAM, driven by directed transactions and a response scoreboard.
module tb_sram_access_ctrl;
    import mem_pkg::*;

    localparam int NI = 3;
    localparam int NS [NI] = '{4, 4, 3};
    localparam int SC [NI] = '{1, 0, 3};

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] req_valid;
    logic          req_we;
    logic [1:0]    req_addr;
    logic [3:0]    req_wdata;
    logic          rsp_ready;

    logic          req_ready   [NI];
    logic          rsp_valid   [NI];
    logic [3:0]    rsp_rdata   [NI];
    logic          rsp_err     [NI];
    logic          mem_cs      [NI];
    logic          mem_wr_en   [NI];
    logic [1:0]    mem_addr    [NI];
    logic [3:0]    mem_wr_data [NI];
    logic [3:0]    mem_rd_data [NI];
    logic [3:0]    sram        [NI][4];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : gen_dut
        sram_access_ctrl #(.N(NS[i]), .W(4), .A(2), .SETUP_CYC(SC[i])) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid[i]),
            .req_ready   (req_ready[i]),
            .req_we      (req_we),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .rsp_valid   (rsp_valid[i]),
            .rsp_ready   (rsp_ready),
            .rsp_rdata   (rsp_rdata[i]),
            .rsp_err     (rsp_err[i]),
            .mem_cs      (mem_cs[i]),
            .mem_wr_en   (mem_wr_en[i]),
            .mem_addr    (mem_addr[i]),
            .mem_wr_data (mem_wr_data[i]),
            .mem_rd_data (mem_rd_data[i])
        );

        always @(posedge clk)
            if (mem_cs[i] && mem_wr_en[i]) sram[i][mem_addr[i]] <= mem_wr_data[i];

        assign mem_rd_data[i] = sram[i][mem_addr[i]];
    end

    typedef struct {
        logic [3:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request on instance d; n counts edges after the accept edge.
    task automatic txn(input int d, input logic we, input logic [1:0] addr,
                       input logic [3:0] wdata, input int exp_cs_n, input int exp_rsp_n,
                       input logic exp_err, input logic [3:0] exp_rdata, input int bp);
        int   cs_first;
        int   cs_cnt;
        int   rsp_n;
        exp_t e;
        logic [3:0] held;
        cs_first = 99;
        cs_cnt   = 0;
        rsp_n    = -1;
        check_eq($sformatf("req_ready_before_%0d", d), req_ready[d], 1'b1);
        rsp_ready    = 1'b0;
        req_valid[d] = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        step();
        req_valid[d] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (mem_cs[d]) begin
                if (cs_first == 99) cs_first = n;
                cs_cnt++;
                check_eq("cs_wr_en", mem_wr_en[d], we);
                check_eq("cs_addr", mem_addr[d], addr);
                if (we) check_eq("cs_wdata", mem_wr_data[d], wdata);
            end
            if (rsp_valid[d]) begin
                rsp_n = n;
                break;
            end
            check_eq("req_ready_busy", req_ready[d], 1'b0);
            step();
        end
        check_eq("cs_time", cs_first, exp_cs_n);
        check_eq("cs_count", cs_cnt, (exp_cs_n == 99) ? 0 : 1);
        check_eq("rsp_time", rsp_n, exp_rsp_n);
        held = rsp_rdata[d];
        for (int k = 0; k < bp; k++) begin
            step();
            check_eq("bp_valid", rsp_valid[d], 1'b1);
            check_eq("bp_rdata", rsp_rdata[d], held);
            check_eq("bp_req_ready", req_ready[d], 1'b0);
            check_eq("bp_cs", mem_cs[d], 1'b0);
        end
        if (sb.size() == 0) begin
            check_eq("sb_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            check_eq("rsp_rdata", rsp_rdata[d], e.rdata);
            check_eq("rsp_err", rsp_err[d], e.err);
        end
        rsp_ready = 1'b1;
        step();
        check_eq("rsp_valid_clear", rsp_valid[d], 1'b0);
        check_eq("req_ready_after", req_ready[d], 1'b1);
    endtask

    task automatic check_reset_vals(input int d);
        check_eq("rst_req_ready", req_ready[d], 1'b1);
        check_eq("rst_rsp_valid", rsp_valid[d], 1'b0);
        check_eq("rst_rsp_rdata", rsp_rdata[d], 4'h0);
        check_eq("rst_rsp_err", rsp_err[d], 1'b0);
        check_eq("rst_mem_cs", mem_cs[d], 1'b0);
        check_eq("rst_mem_wr_en", mem_wr_en[d], 1'b0);
        check_eq("rst_mem_addr", mem_addr[d], 2'd0);
        check_eq("rst_mem_wr_data", mem_wr_data[d], 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int cs_seen;
        int rv_seen;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        for (int d = 0; d < NI; d++) check_reset_vals(d);

        // SETUP_CYC=1: write then read back
        txn(0, 1'b1, 2'd2, 4'hA, 1, 2, 1'b0, 4'h0, 0);
        txn(0, 1'b0, 2'd2, 4'h0, 1, 2, 1'b0, 4'hA, 0);

        // SETUP_CYC=0
        txn(1, 1'b1, 2'd1, 4'h5, 0, 1, 1'b0, 4'h0, 0);
        txn(1, 1'b0, 2'd1, 4'h0, 0, 1, 1'b0, 4'h5, 0);

        // back-pressured read
        txn(0, 1'b0, 2'd2, 4'h0, 1, 2, 1'b0, 4'hA, 5);

        // out of range on N=3
        txn(2, 1'b0, 2'd3, 4'h7, 99, 0, 1'b1, 4'h0, 0);

        // reset during SETUP on SETUP_CYC=3
        cs_seen = 0;
        rv_seen = 0;
        rsp_ready    = 1'b0;
        req_valid[2] = 1'b1;
        req_we       = 1'b1;
        req_addr     = 2'd1;
        req_wdata    = 4'hF;
        step();
        req_valid[2] = 1'b0;
        check_eq("mid_setup_busy", req_ready[2], 1'b0);
        step();
        check_eq("mid_setup_no_cs", mem_cs[2], 1'b0);
        check_eq("mid_setup_wr_en", mem_wr_en[2], 1'b1);
        rst = 1'b1;
        step();
        check_reset_vals(2);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (mem_cs[2]) cs_seen++;
            if (rsp_valid[2]) rv_seen++;
            step();
        end
        check_eq("post_rst_cs", cs_seen, 0);
        check_eq("post_rst_rsp", rv_seen, 0);
        rsp_ready = 1'b1;

        // data integrity: write 1..4, read back in reverse
        for (int a = 0; a < 4; a++)
            txn(0, 1'b1, 2'(a), 4'(a + 1), 1, 2, 1'b0, 4'h0, 0);
        for (int a = 3; a >= 0; a--)
            txn(0, 1'b0, 2'(a), 4'h0, 1, 2, 1'b0, 4'(a + 1), 0);

        check_eq("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
